// File: rtl/hilo_if.sv
// HI/LO unit request/response bundle: write and read requests from the pipeline,
// and registered read data, busy and stall back to it.
interface hilo_if;
  logic        op_valid;
  logic [1:0]  op_kind;
  logic [31:0] wr_lo;
  logic [31:0] wr_hi;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        stall;

  modport master (
    output op_valid, op_kind, wr_lo, wr_hi, rd_req, rd_sel,
    input  rd_data, rd_valid, busy, stall
  );

  modport slave (
    input  op_valid, op_kind, wr_lo, wr_hi, rd_req, rd_sel,
    output rd_data, rd_valid, busy, stall
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: multiply/divide results commit after a fixed latency.
// Optional macro HILO_FORWARD_EN forwards same-cycle mthi/mtlo data to reads.
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);
  // state | meaning
  // IDLE  | accepts reads, mthi/mtlo and new multiply/divide
  // BUSY  | result in flight; all requests stall until commit
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] sh_hi_q, sh_lo_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q;
  logic [31:0] rd_hi, rd_lo;

  always_comb begin
    rd_hi = hi_q;
    rd_lo = lo_q;
`ifdef HILO_FORWARD_EN
    if (bus.op_valid && bus.op_kind == 2'b10) rd_hi = bus.wr_hi;
    if (bus.op_valid && bus.op_kind == 2'b11) rd_lo = bus.wr_lo;
`else
`endif
    rd_data_d = bus.rd_sel ? rd_hi : rd_lo;
  end

  // Reset wins over a busy stall so the requester is never told to retry during reset.
  assign bus.stall    = (state_q == BUSY) && !rst && (bus.op_valid || bus.rd_req);
  assign bus.busy     = (state_q == BUSY);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      sh_hi_q    <= 32'd0;
      sh_lo_q    <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rd_req) begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= 1'b1;
          end
          if (bus.op_valid) begin
            case (bus.op_kind)
              2'b00, 2'b01: begin
                sh_hi_q <= bus.wr_hi;
                sh_lo_q <= bus.wr_lo;
                cnt_q   <= (bus.op_kind == 2'b00) ? MUL_CNT : DIV_CNT;
                state_q <= BUSY;
              end
              2'b10:   hi_q <= bus.wr_hi;
              default: lo_q <= bus.wr_lo;
            endcase
          end
        end
        BUSY: begin
          if (cnt_q == 6'd0) begin
            hi_q    <= sh_hi_q;
            lo_q    <= sh_lo_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed scenarios then random traffic,
// checked against a cycle-level model of the HI/LO architectural behaviour.
module tb_hilo_unit;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst;
  hilo_if bus ();

  hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] m_pend_hi, m_pend_lo;
  int          m_busy_rem = 0;
  logic [31:0] exp_q[$];

  // Monitor: registered outputs sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e;
    checks++;
    if (bus.busy !== (m_busy_rem > 0)) begin
      errors++;
      $display("FAIL busy: got %b expected %b at %0t", bus.busy, (m_busy_rem > 0), $time);
    end
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid: unexpected pulse, rd_data %h at %0t", bus.rd_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h at %0t", bus.rd_data, e, $time);
        end
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL rd_valid: missing pulse, got %b expected 1 (data %h) at %0t",
               bus.rd_valid, e, $time);
    end
  end

  task automatic cyc(input logic r, input logic ov, input logic [1:0] k,
                     input logic [31:0] lo, input logic [31:0] hi,
                     input logic rq, input logic sl);
    logic exp_stall;
    logic [31:0] rv_hi, rv_lo;
    @(negedge clk);
    rst = r;
    bus.op_valid = ov; bus.op_kind = k; bus.wr_lo = lo; bus.wr_hi = hi;
    bus.rd_req = rq; bus.rd_sel = sl;
    #1;
    exp_stall = !r && (m_busy_rem > 0) && (ov || rq);
    checks++;
    if (bus.stall !== exp_stall) begin
      errors++;
      $display("FAIL stall: got %b expected %b at %0t", bus.stall, exp_stall, $time);
    end
    @(posedge clk);
    if (r) begin
      m_hi = 0; m_lo = 0; m_busy_rem = 0;
    end else if (m_busy_rem > 0) begin
      m_busy_rem--;
      if (m_busy_rem == 0) begin
        m_hi = m_pend_hi; m_lo = m_pend_lo;
      end
    end else begin
      rv_hi = m_hi; rv_lo = m_lo;
`ifdef HILO_FORWARD_EN
      if (ov && k == 2'b10) rv_hi = hi;
      if (ov && k == 2'b11) rv_lo = lo;
`endif
      if (rq) exp_q.push_back(sl ? rv_hi : rv_lo);
      if (ov) begin
        case (k)
          2'b00: begin m_busy_rem = MUL_LAT; m_pend_hi = hi; m_pend_lo = lo; end
          2'b01: begin m_busy_rem = DIV_LAT; m_pend_hi = hi; m_pend_lo = lo; end
          2'b10: m_hi = hi;
          default: m_lo = lo;
        endcase
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.op_valid = 0; bus.op_kind = 0; bus.wr_lo = 0; bus.wr_hi = 0;
    bus.rd_req = 0; bus.rd_sel = 0;
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    // reset value read
    cyc(0, 0, 2'b00, 0, 0, 1, 1);
    idle(1);
    // mthi then mfhi
    cyc(0, 1, 2'b10, 0, 32'h12345678, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 1);
    idle(1);
    // multiply, stalled reads during busy, then read result
    cyc(0, 1, 2'b00, 32'hFFFFFFFE, 32'h1, 0, 0);
    for (int i = 0; i < MUL_LAT; i++) cyc(0, 0, 2'b00, 0, 0, 1, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 1);
    // divide abandoned by reset
    cyc(0, 1, 2'b01, 32'hDEAD0001, 32'hBEEF0002, 0, 0);
    idle(9);
    cyc(1, 1, 2'b11, 32'h1, 32'h1, 1, 1);
    cyc(0, 0, 2'b00, 0, 0, 1, 1);
    cyc(0, 0, 2'b00, 0, 0, 1, 0);
    idle(DIV_LAT + 2);
    // same-cycle mtlo and mflo
    cyc(0, 1, 2'b11, 32'hAAAA0000, 0, 0, 0);
    cyc(0, 1, 2'b11, 32'h00005555, 0, 1, 0);
    cyc(0, 1, 2'b10, 0, 32'h99, 1, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 0);
    // read older than a same-cycle multiply
    cyc(0, 1, 2'b10, 0, 32'h7, 0, 0);
    cyc(0, 1, 2'b00, 32'h11, 32'h22, 1, 1);
    for (int i = 0; i < MUL_LAT; i++) cyc(0, 0, 2'b00, 0, 0, 1, 1);
    cyc(0, 0, 2'b00, 0, 0, 1, 1);
    cyc(0, 0, 2'b00, 0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] k;
      k = 2'($urandom_range(0, 3));
      if (k == 2'b01 && $urandom_range(0, 3) != 0) k = 2'b10;
      cyc(($urandom_range(0, 150) == 0), ($urandom_range(0, 2) == 0), k,
          $urandom, $urandom, ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)));
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
